pc_fetch_ctrl: RTL

//  Consumer of the branch unit's pc_branch/muxcontrol pair.

---
 rtl/pc_fetch_ctrl_pkg.sv | 21 ++
 rtl/pc_fetch_ctrl_if.sv | 34 +++
 rtl/pc_fetch_ctrl_timer.sv | 34 +++
 rtl/pc_fetch_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Package pc_fetch_pkg: shared types and constants for the PC / fetch controller.
//   fetch_state_e      : fetch FSM states (S_REQ, S_WAIT, S_HOLD)
//   PC_INC             : sequential PC step
//   NOP_INSTR_DEFAULT  : instruction presented when nothing is held
//   align_word()       : clears the two low address bits of a target
package pc_fetch_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_e;

   localparam logic [31:0] PC_INC            = 32'd4;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Interface pc_fetch_ctrl_if: instruction-memory fetch bus.
//   imem_req_valid / imem_req_ready / imem_addr : request channel (fetch -> imem)
//   imem_rsp_valid / imem_rdata                 : response channel (imem -> fetch)
// Handshake: a request transfers on a rising edge where imem_req_valid and
// imem_req_ready are both high; imem_addr is stable while imem_req_valid is
// high and not yet accepted. The response channel has no ready: imem_rsp_valid
// is a one-cycle pulse carrying imem_rdata, and the fetch side always accepts it.
// modport master : fetch controller side
// modport slave  : instruction memory side
interface pc_fetch_ctrl_if;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req_valid,
      output imem_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rdata
   );

endinterface

// File: rtl/pc_fetch_ctrl_timer.sv
// Module fetch_timer: wait counter for an outstanding fetch.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : restart the count (request accepted)
//   run        : count this cycle (FSM is waiting for a response)
//   expired    : count has reached TIMEOUT-1
// The counter saturates at TIMEOUT-1, so an expiry that the FSM cannot act on
// in the same cycle (e.g. a redirect wins) is still visible the next cycle.
module fetch_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT) + 1;

   logic [CW-1:0] cnt_q;

   assign expired = (cnt_q >= CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (run && !expired) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Module pc_fetch_ctrl: architectural PC owner and single-instruction fetch unit.
// Fetches one instruction at pc over the imem bus, holds it for decode/execute,
// and on retire advances pc to the branch target (muxcontrol) or pc+4.
// flush redirects to flush_pc from any state and has highest priority.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   pc_branch, muxcontrol : branch target / branch taken, sampled at retire
//   stall                 : core cannot retire the held instruction
//   flush, flush_pc       : redirect request and target
//   bus (master)          : imem request/response channel
//   instr_valid, instr, instr_pc : held instruction (NOP_INSTR when empty)
//   pc                    : architectural PC (also the fetch address)
//   retire_cnt            : retired instruction count, wraps
//   fetch_err             : one-cycle pulse on fetch timeout
//   misalign_trap         : only with MISALIGN_TRAP_EN; set on a misaligned
//                           taken branch, held until flush
//   state_dbg             : current FSM state
// Build option: define MISALIGN_TRAP_EN to trap misaligned taken branches;
// otherwise the target's low two bits are forced to zero.
module pc_fetch_ctrl
   import pc_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned TIMEOUT      = 16,
   parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           pc_branch,
   input  logic                  muxcontrol,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [31:0]           flush_pc,
   pc_fetch_ctrl_if.master       bus,
   output logic                  instr_valid,
   output logic [31:0]           instr,
   output logic [31:0]           instr_pc,
   output logic [31:0]           pc,
   output logic [31:0]           retire_cnt,
   output logic                  fetch_err,
`ifdef MISALIGN_TRAP_EN
   output logic                  misalign_trap,
`endif
   output fetch_state_e          state_dbg
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  instr_pc_q, instr_pc_d;
   logic [31:0]  retire_cnt_q, retire_cnt_d;
   logic         kill_q, kill_d;
   logic         fetch_err_q, fetch_err_d;
   logic         req_valid_q;
   logic         instr_valid_q;
   logic         accept;
   logic         timer_clear;
   logic         timer_expired;
   logic [31:0]  next_seq_pc;
`ifdef MISALIGN_TRAP_EN
   logic         trap_q, trap_d;
`endif

   assign accept      = (state_q == S_REQ) && req_valid_q && bus.imem_req_ready;
   assign next_seq_pc = pc_q + PC_INC;

   fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clear),
      .run     (state_q == S_WAIT),
      .expired (timer_expired)
   );

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      instr_pc_d   = instr_pc_q;
      retire_cnt_d = retire_cnt_q;
      kill_d       = kill_q;
      fetch_err_d  = 1'b0;
      timer_clear  = 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap_d       = trap_q;
`endif

      case (state_q)
         S_REQ: begin
            if (accept) begin
               state_d     = S_WAIT;
               timer_clear = 1'b1;
            end
         end
         S_WAIT: begin
            if (bus.imem_rsp_valid) begin
               if (kill_q) begin
                  // Response belongs to a fetch that was abandoned.
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  instr_d    = bus.imem_rdata;
                  instr_pc_d = pc_q;
                  state_d    = S_HOLD;
               end
            end else if (timer_expired) begin
               // The original response may still arrive; mark it stale.
               fetch_err_d = 1'b1;
               kill_d      = 1'b1;
               state_d     = S_REQ;
            end
         end
         S_HOLD: begin
            if (!stall) begin
`ifdef MISALIGN_TRAP_EN
               if (muxcontrol && (pc_branch[1:0] != 2'b00)) begin
                  trap_d = 1'b1;
               end else begin
                  pc_d         = muxcontrol ? pc_branch : next_seq_pc;
                  retire_cnt_d = retire_cnt_q + 32'd1;
                  state_d      = S_REQ;
               end
`else
               pc_d         = muxcontrol ? align_word(pc_branch) : next_seq_pc;
               retire_cnt_d = retire_cnt_q + 32'd1;
               state_d      = S_REQ;
`endif
            end
         end
         default: state_d = S_REQ;
      endcase

      // Redirect overrides everything computed above except request bookkeeping.
      if (flush) begin
         pc_d         = flush_pc;
         retire_cnt_d = retire_cnt_q;
         instr_d      = instr_q;
         instr_pc_d   = instr_pc_q;
         fetch_err_d  = 1'b0;
`ifdef MISALIGN_TRAP_EN
         trap_d       = 1'b0;
`endif
         case (state_q)
            S_WAIT: begin
               if (bus.imem_rsp_valid) begin
                  // The outstanding response arrives now: drop it and refetch.
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  kill_d  = 1'b1;
                  state_d = S_WAIT;
               end
            end
            S_REQ: begin
               // An accepted request still returns a response that must be dropped.
               if (accept) begin
                  kill_d  = 1'b1;
                  state_d = S_WAIT;
               end else begin
                  state_d = S_REQ;
               end
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_REQ;
         pc_q          <= RESET_VECTOR;
         instr_q       <= NOP_INSTR;
         instr_pc_q    <= '0;
         retire_cnt_q  <= '0;
         kill_q        <= 1'b0;
         fetch_err_q   <= 1'b0;
         req_valid_q   <= 1'b0;
         instr_valid_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         trap_q        <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         retire_cnt_q  <= retire_cnt_d;
         kill_q        <= kill_d;
         fetch_err_q   <= fetch_err_d;
         req_valid_q   <= (state_d == S_REQ);
         instr_valid_q <= (state_d == S_HOLD);
`ifdef MISALIGN_TRAP_EN
         trap_q        <= trap_d;
`endif
      end
   end

   assign bus.imem_req_valid = req_valid_q;
   assign bus.imem_addr      = pc_q;
   assign instr_valid        = instr_valid_q;
   assign instr              = instr_valid_q ? instr_q : NOP_INSTR;
   assign instr_pc           = instr_pc_q;
   assign pc                 = pc_q;
   assign retire_cnt         = retire_cnt_q;
   assign fetch_err          = fetch_err_q;
   assign state_dbg          = state_q;
`ifdef MISALIGN_TRAP_EN
   assign misalign_trap      = trap_q;
`endif

endmodule
